// File: rtl/viterbi_frame_ctrl_if.sv
// Bus between the frame sequencer and its payload source, encoder, channel and decoder.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface viterbi_frame_ctrl_if;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        bit_req_o;
    logic        bit_i;
    logic        enable_encoder_o;
    logic        encoder_i_o;
    logic        valid_encoder_i;
    logic [1:0]  err_inj_o;
    logic        enable_decoder_o;
    logic        decoder_i;
    logic [15:0] sym_err_ct_o;
    logic [15:0] bit_err_ct_o;

    modport master (
        input  start_i, bit_i, valid_encoder_i, decoder_i,
        output busy_o, done_o, bit_req_o, enable_encoder_o, encoder_i_o,
               err_inj_o, enable_decoder_o, sym_err_ct_o, bit_err_ct_o
    );

    modport slave (
        output start_i, bit_i, valid_encoder_i, decoder_i,
        input  busy_o, done_o, bit_req_o, enable_encoder_o, encoder_i_o,
               err_inj_o, enable_decoder_o, sym_err_ct_o, bit_err_ct_o
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: feeds payload plus flush tail to the encoder, schedules channel errors
// per symbol, and scores decoder output against a delayed reference copy of the payload.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned TAIL      = 2,
    parameter int unsigned DEC_LAT   = 32,
    parameter int unsigned N         = 5,
    parameter int unsigned ERR_START = 27,
    parameter int unsigned ERR_LEN   = 4,
    parameter int unsigned ERR_LIMIT = 256,
    parameter logic [1:0]  ERR_MASK  = 2'b01
) (
    input logic                  clk,
    input logic                  rst_n,
    viterbi_frame_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_PAYLOAD, S_TAIL, S_DRAIN, S_DONE} state_e;

    localparam logic [15:0] FRAME_LAST  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TAIL_LAST   = 16'(TAIL - 1);
    localparam logic [15:0] DRAIN_LAST  = 16'(DEC_LAT - 1);
    localparam logic [16:0] MASK_WEIGHT = 17'(ERR_MASK[0]) + 17'(ERR_MASK[1]);

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          sym_idx_q, sym_idx_d;
    logic [15:0]          sym_err_q, sym_err_d;
    logic [15:0]          bit_err_q, bit_err_d;
    logic [DEC_LAT-1:0]   pipe_vld_q, pipe_vld_d;
    logic [DEC_LAT-1:0]   pipe_bit_q, pipe_bit_d;
    logic                 en_dec_q;

    logic        busy, done, bitReq, encEnable, encBit, payloadCycle;
    logic        startAccept, inject, mismatch;
    logic [31:0] winPos;
    logic [16:0] symSum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt runs 0..FRAME_LEN-1 in PAYLOAD, then restarts and runs continuously
    // through TAIL and DRAIN so DRAIN ends DEC_LAT cycles after the last payload bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_PAYLOAD;
                    cnt_d   = '0;
                end
            end
            S_PAYLOAD: begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = (TAIL == 0) ? S_DRAIN : S_TAIL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TAIL: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == TAIL_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DRAIN_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b1;
        done      = 1'b0;
        bitReq    = 1'b0;
        encEnable = 1'b0;
        encBit    = 1'b0;
        case (state_q)
            S_IDLE:    busy = 1'b0;
            S_PAYLOAD: begin
                bitReq    = 1'b1;
                encEnable = 1'b1;
                encBit    = bus.bit_i;
            end
            S_TAIL:    encEnable = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    assign payloadCycle = (state_q == S_PAYLOAD);
    assign startAccept  = (state_q == S_IDLE) && bus.start_i;

    assign winPos = 32'(sym_idx_q[N-1:0]);
    assign inject = bus.valid_encoder_i && busy && (32'(sym_idx_q) < ERR_LIMIT)
                    && (winPos >= ERR_START) && (winPos < ERR_START + ERR_LEN);

    assign mismatch = pipe_vld_q[DEC_LAT-1] && (pipe_bit_q[DEC_LAT-1] != bus.decoder_i);
    assign symSum   = {1'b0, sym_err_q} + MASK_WEIGHT;

    always_comb begin
        sym_idx_d  = sym_idx_q;
        sym_err_d  = sym_err_q;
        bit_err_d  = bit_err_q;
        pipe_vld_d = (pipe_vld_q << 1) | DEC_LAT'(payloadCycle);
        pipe_bit_d = (pipe_bit_q << 1) | DEC_LAT'(payloadCycle && bus.bit_i);
        if (startAccept) begin
            sym_idx_d  = '0;
            sym_err_d  = '0;
            bit_err_d  = '0;
            pipe_vld_d = '0;
            pipe_bit_d = '0;
        end else begin
            if (busy && bus.valid_encoder_i) sym_idx_d = sym_idx_q + 16'd1;
            if (inject) sym_err_d = symSum[16] ? 16'hFFFF : symSum[15:0];
            if (mismatch && (bit_err_q != 16'hFFFF)) bit_err_d = bit_err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_idx_q  <= '0;
            sym_err_q  <= '0;
            bit_err_q  <= '0;
            pipe_vld_q <= '0;
            pipe_bit_q <= '0;
            en_dec_q   <= 1'b0;
        end else begin
            sym_idx_q  <= sym_idx_d;
            sym_err_q  <= sym_err_d;
            bit_err_q  <= bit_err_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_bit_q <= pipe_bit_d;
            en_dec_q   <= bus.valid_encoder_i;
        end
    end

    assign bus.busy_o           = busy;
    assign bus.done_o           = done;
    assign bus.bit_req_o        = bitReq;
    assign bus.enable_encoder_o = encEnable;
    assign bus.encoder_i_o      = encBit;
    assign bus.err_inj_o        = inject ? ERR_MASK : 2'b00;
    assign bus.enable_decoder_o = en_dec_q;
    assign bus.sym_err_ct_o     = sym_err_q;
    assign bus.bit_err_ct_o     = bit_err_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: three parameterisations share one stimulus stream and are
// checked cycle by cycle against a frame-timeline model built from relative cycle numbers.
module tb_viterbi_frame_ctrl;
    localparam int FL    = 256;
    localparam int TL    = 2;
    localparam int DL    = 32;
    localparam int NW    = 5;
    localparam int ES    = 27;
    localparam int LIMIT = 256;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] prevA, prevB, prevC;

    viterbi_frame_ctrl_if busA();
    viterbi_frame_ctrl_if busB();
    viterbi_frame_ctrl_if busC();

    viterbi_frame_ctrl uA (.clk(clk), .rst_n(rst_n), .bus(busA));
    viterbi_frame_ctrl #(.ERR_MASK(2'b11)) uB (.clk(clk), .rst_n(rst_n), .bus(busB));
    viterbi_frame_ctrl #(.ERR_LEN(0))      uC (.clk(clk), .rst_n(rst_n), .bus(busC));

    always #5 clk = ~clk;

    task automatic drive(input logic st, input logic b, input logic v, input logic d);
        busA.start_i = st; busB.start_i = st; busC.start_i = st;
        busA.bit_i = b;    busB.bit_i = b;    busC.bit_i = b;
        busA.valid_encoder_i = v; busB.valid_encoder_i = v; busC.valid_encoder_i = v;
        busA.decoder_i = d; busB.decoder_i = d; busC.decoder_i = d;
    endtask

    // Error window rule applied to an absolute symbol number.
    function automatic logic [1:0] expInj(input int s, input int len, input logic [1:0] mask);
        int pos;
        pos = s % (1 << NW);
        if (s < LIMIT && pos >= ES && pos < ES + len) return mask;
        return 2'b00;
    endfunction

    function automatic int expSym(input int len, input logic [1:0] mask);
        int total;
        total = 0;
        for (int s = 0; s < FL + TL; s++)
            if (expInj(s, len, mask) != 2'b00) total += int'(mask[0]) + int'(mask[1]);
        return (total > 65535) ? 65535 : total;
    endfunction

    task automatic check_counters(input string name, input logic [31:0] expA,
                                  input logic [31:0] expB, input logic [31:0] expC);
        logic [31:0] obs;
        obs = {busA.sym_err_ct_o, busA.bit_err_ct_o};
        checks++;
        if (obs !== expA) begin
            errors++;
            $display("[TB] FAIL %s instA sym/bit got %h want %h", name, obs, expA);
        end
        obs = {busB.sym_err_ct_o, busB.bit_err_ct_o};
        checks++;
        if (obs !== expB) begin
            errors++;
            $display("[TB] FAIL %s instB sym/bit got %h want %h", name, obs, expB);
        end
        obs = {busC.sym_err_ct_o, busC.bit_err_ct_o};
        checks++;
        if (obs !== expC) begin
            errors++;
            $display("[TB] FAIL %s instC sym/bit got %h want %h", name, obs, expC);
        end
    endtask

    // One frame, cycle r relative to the start-accept cycle (r=0) up to the done cycle.
    task automatic run_frame(input bit invertDec, input bit glitch, input int rstAt);
        logic        payload [FL];
        logic        st, b, v, d, busyExp;
        logic [5:0]  tObs, tExp;
        logic [5:0]  iObs, iExp;
        logic [15:0] bitsExp;
        int          reqCount, s;
        bit          sawActivity;

        for (int k = 0; k < FL; k++) payload[k] = 1'($urandom);
        bitsExp  = invertDec ? 16'(FL) : 16'd0;
        reqCount = 0;

        for (int r = 0; r <= FL + DL + 1; r++) begin
            @(negedge clk);
            st = (r == 0) || (glitch && (r == 50 || r == FL + 5 || r == FL + DL + 1));
            b  = (r >= 1 && r <= FL) ? payload[r-1] : 1'($urandom);
            v  = (r >= 2 && r <= FL + TL + 1);
            d  = (r >= DL + 1 && r <= FL + DL) ? (payload[r-1-DL] ^ invertDec) : 1'($urandom);
            drive(st, b, v, d);
            #1;

            busyExp = (r >= 1 && r <= FL + DL + 1);
            tExp = {busyExp, (r == FL + DL + 1), (r >= 1 && r <= FL), (r >= 1 && r <= FL + TL),
                    (r >= 1 && r <= FL) ? b : 1'b0, (r >= 3 && r <= FL + TL + 2)};
            tObs = {busA.busy_o, busA.done_o, busA.bit_req_o, busA.enable_encoder_o,
                    busA.encoder_i_o, busA.enable_decoder_o};
            checks++;
            if (tObs !== tExp) begin
                errors++;
                $display("[TB] FAIL timing r=%0d busy/done/req/en/enc/endec got %b want %b",
                         r, tObs, tExp);
            end

            s    = r - 2;
            iExp = (v && busyExp) ? {expInj(s, 4, 2'b01), expInj(s, 4, 2'b11), expInj(s, 0, 2'b01)}
                                  : 6'b0;
            iObs = {busA.err_inj_o, busB.err_inj_o, busC.err_inj_o};
            checks++;
            if (iObs !== iExp) begin
                errors++;
                $display("[TB] FAIL err_inj r=%0d sym=%0d A/B/C got %b want %b", r, s, iObs, iExp);
            end

            if (busA.bit_req_o === 1'b1) reqCount++;
            if (r == 0) check_counters("hold", prevA, prevB, prevC);
            if (r == 1) check_counters("clear", 32'd0, 32'd0, 32'd0);

            if (r == rstAt) begin
                rst_n = 1'b0;
                drive(1'b0, 1'b1, 1'b1, 1'b0);
                #1;
                tObs = {busA.busy_o, busA.done_o, busA.bit_req_o, busA.enable_encoder_o,
                        busA.encoder_i_o, busA.enable_decoder_o};
                iObs = {busA.err_inj_o, busB.err_inj_o, busC.err_inj_o};
                checks++;
                if ({tObs, iObs} !== 12'd0) begin
                    errors++;
                    $display("[TB] FAIL mid_reset outputs got %b want 0", {tObs, iObs});
                end
                check_counters("mid_reset", 32'd0, 32'd0, 32'd0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                sawActivity = 1'b0;
                for (int i = 0; i < 2 * DL; i++) begin
                    @(negedge clk);
                    #1;
                    if (busA.done_o !== 1'b0 || busA.busy_o !== 1'b0) sawActivity = 1'b1;
                end
                checks++;
                if (sawActivity) begin
                    errors++;
                    $display("[TB] FAIL post_reset_quiet got activity=1 want 0");
                end
                @(posedge clk);
                prevA = '0; prevB = '0; prevC = '0;
                return;
            end

            if (r == FL + DL + 1) begin
                prevA = {16'(expSym(4, 2'b01)), bitsExp};
                prevB = {16'(expSym(4, 2'b11)), bitsExp};
                prevC = {16'(expSym(0, 2'b01)), bitsExp};
                check_counters("final", prevA, prevB, prevC);
            end
            @(posedge clk);
        end

        checks++;
        if (reqCount != FL) begin
            errors++;
            $display("[TB] FAIL bit_req_count got %0d want %0d", reqCount, FL);
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        obs = {busA.busy_o, busA.done_o, busA.bit_req_o, busA.enable_encoder_o,
               busA.encoder_i_o, busA.enable_decoder_o,
               busA.err_inj_o, busB.err_inj_o, busC.err_inj_o};
        checks++;
        if (obs !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b want 0", obs);
        end
        check_counters("reset", 32'd0, 32'd0, 32'd0);
        prevA = '0; prevB = '0; prevC = '0;
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_clean_frame();
        $display("[TB] clean frame, ideal decoder");
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_inverted_decoder();
        $display("[TB] decoder returns inverted reference");
        run_frame(1'b1, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        $display("[TB] start pulses while busy");
        run_frame(1'b0, 1'b1, -1);
    endtask

    task automatic test_reset_mid_frame();
        $display("[TB] reset at payload bit 100, then clean frame");
        run_frame(1'b0, 1'b0, 101);
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        $display("[TB] back-to-back frames");
        run_frame(1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b0, -1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_counters("idle_hold", prevA, prevB, prevC);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_inverted_decoder();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer for the convolutional encoder → channel → Viterbi decoder path. It pulls one frame of payload bits from a source and drives the encoder enable and data, appending zero tail bits to flush the encoder. It schedules channel error injection per encoded symbol and delays a reference copy of the payload to score decoder output, counting injected and residual bit errors. It replaces the free-running enable/error logic around the encoder and decoder instances.

## Interface
- FRAME_LEN, 256: payload bits per frame (1..65535).
- TAIL, 2: zero flush bits after payload (K-1 of encoder).
- DEC_LAT, 32: cycles from a payload bit on encoder_i_o (enable high) to its decoded bit on decoder_i; must be ≥ TAIL+1, ≤ 255.
- N, 5: error window size is 2**N symbols.
- ERR_START, 27: first symbol offset in window that gets errors.
- ERR_LEN, 4: consecutive errored symbols per window; 0 disables injection.
- ERR_LIMIT, 256: no injection at symbol index ≥ ERR_LIMIT.
- ERR_MASK, 2'b01: bits XORed into an errored symbol.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  frame request; accepted only in IDLE.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame end.
- bit_req_o  out  1  payload bit consumed this cycle.
- bit_i  in  1  payload bit; valid when bit_req_o=1.
- enable_encoder_o  out  1  encoder enable.
- encoder_i_o  out  1  encoder data input.
- valid_encoder_i  in  1  encoder symbol valid.
- err_inj_o  out  2  error mask for current encoder symbol.
- enable_decoder_o  out  1  decoder enable (valid_encoder_i delayed 1 cycle, matching channel register).
- decoder_i  in  1  decoded bit.
- sym_err_ct_o  out  16  channel bits flipped this frame.
- bit_err_ct_o  out  16  payload bits decoded wrong this frame.

## Operation
- States: IDLE, PAYLOAD, TAIL, DRAIN, DONE.
- IDLE: start_i=1 → clear counters, symbol index, reference pipeline; go PAYLOAD. Otherwise stay.
- PAYLOAD: bit_req_o=1, enable_encoder_o=1, encoder_i_o=bit_i (combinational); payload counter increments; after FRAME_LEN cycles → TAIL.
- TAIL: enable_encoder_o=1, encoder_i_o=0, bit_req_o=0; after TAIL cycles → DRAIN.
- DRAIN: encoder idle; wait until last payload bit compared → DONE.
- DONE: done_o=1 for one cycle → IDLE. busy_o=1 in PAYLOAD, TAIL, DRAIN, DONE.
- start_i outside IDLE ignored.
- Symbol index s (16-bit): increments on each valid_encoder_i=1 while busy_o=1; starts 0 per frame.
- err_inj_o = ERR_MASK when valid_encoder_i=1, busy_o=1, s<ERR_LIMIT, ERR_START ≤ s[N-1:0] < ERR_START+ERR_LEN; else 2'b00 (combinational).
- sym_err_ct_o += popcount(ERR_MASK) per injected symbol.
- Reference pipeline: DEC_LAT-deep shift of {valid,bit}; shifts every cycle; entry valid=1 with bit=bit_i only in PAYLOAD cycles. When output entry valid=1, compare to decoder_i; mismatch → bit_err_ct_o += 1.
- Counters saturate at 16'hFFFF; hold values after done_o until next accepted start.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, pipeline cleared; reset mid-frame aborts immediately, no done_o.
- start_i accepted cycle T: payload cycles T+1..T+FRAME_LEN; tail T+FRAME_LEN+1..T+FRAME_LEN+TAIL.
- Payload bit k (sent T+1+k) compared at cycle T+1+k+DEC_LAT.
- Last compare T+FRAME_LEN+DEC_LAT; done_o at T+FRAME_LEN+DEC_LAT+1; busy_o high T+1 through done cycle; new start accepted from T+FRAME_LEN+DEC_LAT+2.
- enable_decoder_o registered: high at cycle c+1 for valid_encoder_i at c.
- Counter values for a frame final in done_o cycle.

## Test plan
- ERR_LEN=0, random payload, ideal decoder model → done_o at T+FRAME_LEN+DEC_LAT+1, sym_err_ct_o=0, bit_err_ct_o=0, exactly 256 bit_req_o cycles.
- Defaults, encoder valid every enable → err_inj_o=01 at symbols 27–30, 59–62, …, 251–254 only; sym_err_ct_o=32.
- ERR_MASK=11, ERR_LEN=4 → sym_err_ct_o=64; symbol 255 and beyond ERR_LIMIT clean.
- decoder_i forced to inverted reference → bit_err_ct_o=256; tail bits never scored.
- start_i pulsed during PAYLOAD → ignored, frame timing unchanged; rst low at payload bit 100 → all outputs 0 immediately, no done_o, next start runs full clean frame.
